// File: rtl/c64_key_matrix_if.sv
// rtl/c64_key_matrix_if.sv - Companion key event, keymap lookup and CIA1 scan bundle
interface c64_key_matrix_if;
    logic       kbd_strobe;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic [6:0] km_code;
    logic [1:0] km_shift_mod;
    logic [3:0] km_row;
    logic [2:0] km_column;
    logic [3:0] km_row_s;
    logic [2:0] km_column_s;
    logic [7:0] pa_i;
    logic [7:0] pb_i;
    logic [7:0] pb_o;
    logic [7:0] pa_o;

    // Event source, keymap and CIA1 side
    modport master (
        output kbd_strobe, kbd_data,
        output km_row, km_column, km_row_s, km_column_s,
        output pa_i, pb_i,
        input  kbd_ready, km_code, km_shift_mod,
        input  pb_o, pa_o
    );

    // Key matrix side
    modport slave (
        input  kbd_strobe, kbd_data,
        input  km_row, km_column, km_row_s, km_column_s,
        input  pa_i, pb_i,
        output kbd_ready, km_code, km_shift_mod,
        output pb_o, pa_o
    );
endinterface

// File: rtl/c64_key_matrix.sv
// rtl/c64_key_matrix.sv - C64 8x8 keyboard matrix fed by Companion key events, scanned by CIA1
module c64_key_matrix #(
    parameter int OUT_REG    = 1,
    parameter int TRACK_HELD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    c64_key_matrix_if.slave      kbd
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [6:0]   km_code_q;
    logic         rel_q;
    logic [63:0]  phys;
    logic [63:0]  inj;
    logic [2:0]   inj_cnt;
    logic [127:0] held;
    logic         lshift_down;
    logic         rshift_down;

    logic         ready_c;
    logic         skip_event;
    logic         key_mapped;
    logic         shift_mapped;
    logic [5:0]   key_pos;
    logic [5:0]   shift_pos;
    logic [63:0]  k_eff;
    logic [7:0]   pb_c;
    logic [7:0]   pa_c;
    logic         col_hit;

    assign kbd.kbd_ready    = ready_c;
    assign kbd.km_code      = km_code_q;
    assign kbd.km_shift_mod = {rshift_down, lshift_down};

    // A repeated press or a release of a key that is not down is ignored when held tracking is on
    assign skip_event   = (TRACK_HELD != 0) && (held[km_code_q] != rel_q);
    assign key_mapped   = (kbd.km_row != 4'd8);
    assign shift_mapped = (kbd.km_row_s != 4'd8);
    assign key_pos      = {kbd.km_row[2:0], kbd.km_column};
    assign shift_pos    = {kbd.km_row_s[2:0], kbd.km_column_s};
    assign k_eff        = phys | inj;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept one event in IDLE, give the keymap a cycle, then apply
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (kbd.kbd_strobe) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_nxt = ST_APPLY;
            ST_APPLY:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Event latch and matrix/held/shift bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            km_code_q   <= '0;
            rel_q       <= 1'b0;
            phys        <= '0;
            inj         <= '0;
            inj_cnt     <= '0;
            held        <= '0;
            lshift_down <= 1'b0;
            rshift_down <= 1'b0;
        end else begin
            if (state == ST_IDLE && kbd.kbd_strobe) begin
                km_code_q <= kbd.kbd_data[6:0];
                rel_q     <= kbd.kbd_data[7];
            end
            if (state == ST_APPLY && !skip_event) begin
                held[km_code_q] <= ~rel_q;
                if (key_mapped) begin
                    phys[key_pos] <= ~rel_q;
                end
                if (shift_mapped) begin
                    if (!rel_q) begin
                        inj[shift_pos] <= 1'b1;
                        if (inj_cnt != 3'd7) begin
                            inj_cnt <= inj_cnt + 3'd1;
                        end
                    end else begin
                        // shift_mod may differ from press time, so the whole injection set goes at once
                        if (inj_cnt <= 3'd1) begin
                            inj_cnt <= 3'd0;
                            inj     <= '0;
                        end else begin
                            inj_cnt <= inj_cnt - 3'd1;
                        end
                    end
                end
                if (km_code_q == 7'h69) begin
                    lshift_down <= ~rel_q;
                end
                if (km_code_q == 7'h6D) begin
                    rshift_down <= ~rel_q;
                end
            end
        end
    end

    // Bidirectional scan: selected columns pull rows low, driven rows pull columns low
    always_comb begin
        pb_c    = '1;
        pa_c    = '1;
        col_hit = 1'b0;
        for (int r = 0; r < 8; r++) begin
            pb_c[r] = kbd.pb_i[r] & ~|(k_eff[r*8 +: 8] & ~kbd.pa_i);
        end
        for (int c = 0; c < 8; c++) begin
            col_hit = 1'b0;
            for (int r = 0; r < 8; r++) begin
                col_hit = col_hit | (k_eff[r*8 + c] & ~kbd.pb_i[r]);
            end
            pa_c[c] = kbd.pa_i[c] & ~col_hit;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [7:0] pb_q;
            logic [7:0] pa_q;

            // Registered scan outputs, released (all high) in reset
            always_ff @(posedge clk) begin
                if (reset) begin
                    pb_q <= 8'hFF;
                    pa_q <= 8'hFF;
                end else begin
                    pb_q <= pb_c;
                    pa_q <= pa_c;
                end
            end

            assign kbd.pb_o = pb_q;
            assign kbd.pa_o = pa_q;
        end else begin : g_out_comb
            assign kbd.pb_o = pb_c;
            assign kbd.pa_o = pa_c;
        end
    endgenerate

endmodule

// File: tb/tb_c64_key_matrix.sv
// tb/tb_c64_key_matrix.sv - self-checking bench for c64_key_matrix
module tb_c64_key_matrix;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    c64_key_matrix_if bus();

    c64_key_matrix #(.OUT_REG(1), .TRACK_HELD(1)) dut (
        .clk   (clk),
        .reset (reset),
        .kbd   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] row;
        logic [2:0] col;
        logic [3:0] row_s;
        logic [2:0] col_s;
    } km_t;

    // Keymap stand-in: a few real C64 positions plus regular filler
    function automatic km_t keymap(input logic [6:0] code, input logic [1:0] sm);
        km_t m;
        m.row = 4'd8; m.col = 3'd0; m.row_s = 4'd8; m.col_s = 3'd0;
        if (code == 7'h04) begin
            m.row = 4'd2; m.col = 3'd1;
        end else if (code == 7'h69) begin
            m.row = 4'd7; m.col = 3'd1;
        end else if (code == 7'h6D) begin
            m.row = 4'd4; m.col = 3'd6;
        end else if (code < 7'h40) begin
            m.row = {1'b0, code[5:3]}; m.col = code[2:0];
        end else if (code >= 7'h50 && code < 7'h58) begin
            m.row = 4'd2; m.col = code[2:0];
            if (sm[0]) begin
                m.row_s = 4'd4; m.col_s = 3'd6;
            end else begin
                m.row_s = 4'd7; m.col_s = 3'd1;
            end
        end
        return m;
    endfunction

    // Combinational keymap environment
    always_comb begin
        km_t m;
        m = keymap(bus.km_code, bus.km_shift_mod);
        bus.km_row      = m.row;
        bus.km_column   = m.col;
        bus.km_row_s    = m.row_s;
        bus.km_column_s = m.col_s;
    end

    // Reference model state
    bit m_held [128];
    bit m_key  [8][8];
    bit m_inj  [8][8];
    int m_cnt;
    bit m_ls;
    bit m_rs;

    task automatic model_clear();
        foreach (m_held[i]) m_held[i] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                m_key[r][c] = 1'b0;
                m_inj[r][c] = 1'b0;
            end
        end
        m_cnt = 0;
        m_ls  = 1'b0;
        m_rs  = 1'b0;
    endtask

    task automatic model_event(input logic [7:0] ev);
        logic [6:0] code;
        bit         is_rel;
        km_t        m;
        code   = ev[6:0];
        is_rel = ev[7];
        m      = keymap(code, {m_rs, m_ls});
        if (m_held[code] == !is_rel) return;
        m_held[code] = !is_rel;
        if (m.row < 8) m_key[m.row[2:0]][m.col] = !is_rel;
        if (m.row_s < 8) begin
            if (!is_rel) begin
                m_inj[m.row_s[2:0]][m.col_s] = 1'b1;
                if (m_cnt < 7) m_cnt++;
            end else begin
                if (m_cnt > 0) m_cnt--;
                if (m_cnt == 0) begin
                    for (int r = 0; r < 8; r++)
                        for (int c = 0; c < 8; c++)
                            m_inj[r][c] = 1'b0;
                end
            end
        end
        if (code == 7'h69) m_ls = !is_rel;
        if (code == 7'h6D) m_rs = !is_rel;
    endtask

    function automatic logic [7:0] model_pb(input logic [7:0] pa, input logic [7:0] pb);
        logic [7:0] res;
        res = pb;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if ((m_key[r][c] || m_inj[r][c]) && !pa[c]) res[r] = 1'b0;
        return res;
    endfunction

    function automatic logic [7:0] model_pa(input logic [7:0] pa, input logic [7:0] pb);
        logic [7:0] res;
        res = pa;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if ((m_key[r][c] || m_inj[r][c]) && !pb[r]) res[c] = 1'b0;
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Wait for ready, strobe one event, let LOOKUP and APPLY pass
    task automatic send_ev(input logic [7:0] ev);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.kbd_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.kbd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        bus.kbd_strobe = 1'b1;
        bus.kbd_data   = ev;
        @(posedge clk);
        #1;
        bus.kbd_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_event(ev);
    endtask

    task automatic scan_check(input string name, input logic [7:0] pa, input logic [7:0] pb,
                              input logic [7:0] exp_pb, input logic [7:0] exp_pa);
        bus.pa_i = pa;
        bus.pb_i = pb;
        @(posedge clk);
        #1;
        check({name, "_pb"}, {24'h0, bus.pb_o}, {24'h0, exp_pb});
        check({name, "_pa"}, {24'h0, bus.pa_o}, {24'h0, exp_pa});
    endtask

    typedef struct {
        bit         has_ev;
        logic [7:0] ev;
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] exp_pb;
        logic [7:0] exp_pa;
    } vec_t;

    vec_t vecs [12];

    logic [7:0] pool [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ev;
        logic [7:0] pa;
        logic [7:0] pb;

        n_cmp = 0;
        n_err = 0;
        model_clear();

        vecs[0]  = '{1'b1, 8'h04, 8'hFD, 8'hFF, 8'hFB, 8'hFD};
        vecs[1]  = '{1'b1, 8'h84, 8'hFD, 8'hFF, 8'hFF, 8'hFD};
        vecs[2]  = '{1'b1, 8'h50, 8'hFE, 8'hFF, 8'hFB, 8'hFE};
        vecs[3]  = '{1'b0, 8'h00, 8'hFD, 8'hFF, 8'h7F, 8'hFD};
        vecs[4]  = '{1'b1, 8'hD0, 8'hFD, 8'hFF, 8'hFF, 8'hFD};
        vecs[5]  = '{1'b1, 8'h69, 8'hFD, 8'hFF, 8'h7F, 8'hFD};
        vecs[6]  = '{1'b1, 8'h50, 8'hBF, 8'hFF, 8'hEF, 8'hBF};
        vecs[7]  = '{1'b1, 8'hD0, 8'hBF, 8'hFF, 8'hFF, 8'hBF};
        vecs[8]  = '{1'b1, 8'hE9, 8'hFD, 8'hFF, 8'hFF, 8'hFD};
        vecs[9]  = '{1'b1, 8'h04, 8'hFF, 8'hFB, 8'hFB, 8'hFD};
        vecs[10] = '{1'b1, 8'h65, 8'hFF, 8'hFB, 8'hFB, 8'hFD};
        vecs[11] = '{1'b1, 8'hE5, 8'hFF, 8'hFB, 8'hFB, 8'hFD};

        pool[0] = 8'h04; pool[1] = 8'h50; pool[2] = 8'h53; pool[3] = 8'h69;
        pool[4] = 8'h6D; pool[5] = 8'h65; pool[6] = 8'h39; pool[7] = 8'h0A;

        // Reset state, with select lines driven so a combinational path would show
        reset          = 1'b1;
        bus.kbd_strobe = 1'b0;
        bus.kbd_data   = 8'h00;
        bus.pa_i       = 8'h00;
        bus.pb_i       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pb_o", {24'h0, bus.pb_o}, 32'hFF);
        check("rst_pa_o", {24'h0, bus.pa_o}, 32'hFF);
        check("rst_ready", {31'h0, bus.kbd_ready}, 32'h1);
        check("rst_km_code", {25'h0, bus.km_code}, 32'h0);
        check("rst_shift_mod", {30'h0, bus.km_shift_mod}, 32'h0);
        reset    = 1'b0;
        bus.pa_i = 8'hFF;
        bus.pb_i = 8'hFF;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].has_ev) send_ev(vecs[i].ev);
            scan_check($sformatf("vec%0d", i), vecs[i].pa, vecs[i].pb, vecs[i].exp_pb, vecs[i].exp_pa);
            if (i == 5) check("lshift_mod", {30'h0, bus.km_shift_mod}, 32'h1);
        end

        // Back-to-back strobes: second one dropped, ready low while busy
        @(negedge clk);
        bus.kbd_strobe = 1'b1;
        bus.kbd_data   = 8'h05;
        @(posedge clk);
        #1;
        check("busy_ready_1", {31'h0, bus.kbd_ready}, 32'h0);
        bus.kbd_data = 8'h06;
        @(posedge clk);
        #1;
        bus.kbd_strobe = 1'b0;
        check("busy_ready_2", {31'h0, bus.kbd_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("busy_ready_3", {31'h0, bus.kbd_ready}, 32'h1);
        model_event(8'h05);
        scan_check("first_kept", 8'hDF, 8'hFF, 8'hFE, 8'hDF);
        scan_check("second_dropped", 8'hBF, 8'hFF, 8'hFF, 8'hBF);
        send_ev(8'h85);

        // Repeated press of a held key, then a single release clears it
        send_ev(8'h04);
        scan_check("repeat_press", 8'hFD, 8'hFF, 8'hFB, 8'hFD);
        send_ev(8'h84);
        scan_check("single_release", 8'hFD, 8'hFF, 8'hFF, 8'hFD);

        // Reset while an event sits in LOOKUP with keys held
        send_ev(8'h04);
        send_ev(8'h69);
        @(negedge clk);
        bus.kbd_strobe = 1'b1;
        bus.kbd_data   = 8'h10;
        @(posedge clk);
        #1;
        bus.kbd_strobe = 1'b0;
        reset          = 1'b1;
        bus.pa_i       = 8'h00;
        bus.pb_i       = 8'hFF;
        @(posedge clk);
        #1;
        check("midrst_pb_o", {24'h0, bus.pb_o}, 32'hFF);
        check("midrst_pa_o", {24'h0, bus.pa_o}, 32'hFF);
        check("midrst_ready", {31'h0, bus.kbd_ready}, 32'h1);
        reset = 1'b0;
        model_clear();
        scan_check("midrst_keys_gone", 8'h00, 8'hFF, 8'hFF, 8'h00);

        // Randomized events against the reference model
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0) ev = pool[$urandom_range(0, 7)];
            else ev = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) ev[7] = 1'b1;
            send_ev(ev);
            pa = 8'($urandom);
            pb = 8'($urandom);
            if ($urandom_range(0, 1) == 0) pb = 8'hFF;
            scan_check($sformatf("rnd%0d", n), pa, pb, model_pb(pa, pb), model_pa(pa, pb));
            check($sformatf("rnd%0d_mod", n), {30'h0, bus.km_shift_mod}, {30'h0, m_rs, m_ls});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
